// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, sequences the synchronous instruction ROM and
// hands {pc, inst} to ID over a valid/allow_in handshake, with WB redirect and cancel.
module fetch_stage #(
    parameter logic [31:0] STARTADDR = 32'h0000_0000,
    parameter int unsigned ROM_LAT   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [32:0] exc_bus,
    input  logic        cancel,
    input  logic [32:0] jbr_bus,
    input  logic        ID_allow_in,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic        IF_valid,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_t;

    // ROM_LAT is at most 4, so the wait counter never exceeds 3.
    localparam logic [1:0] CntLast = 2'(ROM_LAT - 1);

    state_t      r_state, w_state_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_inst, w_inst_d;
    logic [1:0]  r_cnt, w_cnt_d;

    logic        w_exc_valid, w_jbr_taken, w_kill, w_handoff;
    logic [31:0] w_exc_pc, w_jbr_pc;

    assign w_exc_valid = exc_bus[32];
    assign w_jbr_taken = jbr_bus[32];
    assign w_exc_pc    = exc_bus[31:0] & 32'hFFFF_FFFC;
    assign w_jbr_pc    = jbr_bus[31:0] & 32'hFFFF_FFFC;
    assign w_kill      = w_exc_valid | cancel;
    assign w_handoff   = (r_state == StReady) & ID_allow_in & ~cancel;

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_inst_d  = r_inst;
        w_cnt_d   = r_cnt;
        // WB redirect/cancel beats handoff and branch; IDLE ignores it.
        if (r_state != StIdle && w_kill) begin
            if (w_exc_valid) begin
                w_pc_d = w_exc_pc;
            end
            w_state_d = StWait;
            w_cnt_d   = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_d = StWait;
                    w_cnt_d   = '0;
                end
                StWait: begin
                    if (r_cnt == CntLast) begin
                        w_inst_d  = inst;
                        w_state_d = StReady;
                    end else begin
                        w_cnt_d = r_cnt + 2'd1;
                    end
                end
                StReady: begin
                    // The handed-off instruction is the delay slot; the branch steers the next one.
                    if (w_handoff) begin
                        w_pc_d    = w_jbr_taken ? w_jbr_pc : r_pc + 32'd4;
                        w_state_d = StWait;
                        w_cnt_d   = '0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_pc    <= STARTADDR;
            r_inst  <= 32'd0;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_d;
            r_pc    <= w_pc_d;
            r_inst  <= w_inst_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign inst_addr = r_pc;
    assign IF_over   = (r_state == StReady) & ~cancel;
    assign IF_valid  = (r_state != StIdle);
    assign IF_ID_bus = {r_pc, r_inst};
    assign IF_pc     = r_pc;
    assign IF_inst   = r_inst;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage of the 5-stage pipeline. It owns the PC, drives the synchronous instruction ROM and presents {pc, inst} to ID over the IF->ID bus using the valid/allow_in handshake.
- It consumes the branch bus from ID, and the exception redirect bus plus cancel from WB.
- It is the receiving end of the WB exception/cancel interface.

Parameters:
- STARTADDR, 32'h00000000, PC value after reset. Low 2 bits must be 0.
- ROM_LAT, 1, instruction ROM read latency in cycles, counted from a stable inst_addr. Legal range 1..4.

Ports:
- clk  input  1  Clock. All state updates on posedge.
- reset  input  1  Synchronous, active-high reset.
- exc_bus  input  33  {exc_valid, exc_pc[31:0]} from WB.
- cancel  input  1  WB kill of all younger instructions. Asserts with exc_valid.
- jbr_bus  input  33  {jbr_taken, jbr_target[31:0]} from ID.
- ID_allow_in  input  1  ID can accept a new instruction this cycle.
- inst_addr  output  32  ROM address. Equals the PC register.
- inst  input  32  ROM read data. Valid ROM_LAT cycles after inst_addr is stable.
- IF_over  output  1  IF_ID_bus holds a valid, completed fetch.
- IF_ID_bus  output  64  {pc[31:0], inst_r[31:0]}.
- IF_valid  output  1  Stage holds a live fetch (state != IDLE).
- IF_pc  output  32  Display copy of pc.
- IF_inst  output  32  Display copy of inst_r.

Behaviour:
- Reset values:
  - pc = STARTADDR, inst_r = 0, cnt = 0, state = IDLE.
  - IF_over = 0, IF_valid = 0, inst_addr = STARTADDR, IF_ID_bus = {STARTADDR, 32'd0}.
- FSM states: IDLE, WAIT, READY.
  - IDLE: lasts exactly one cycle after reset deassert, then -> WAIT with cnt = 0.
  - WAIT: inst_addr held at pc. cnt increments each cycle. When cnt == ROM_LAT-1, on that edge: inst_r <= inst, state -> READY.
  - READY: IF_over = 1 unless masked by cancel. inst_r and pc are held while ID_allow_in = 0.
- Handoff edge: READY & ID_allow_in & !cancel. On this edge:
  - ID captures IF_ID_bus.
  - pc <= jbr_taken ? jbr_target : pc+4.
  - state -> WAIT, cnt <= 0.
  - jbr_bus is sampled only on the handoff edge and ignored in all other cycles. This implements the delay slot: the instruction handed off is the slot, and the redirect applies to the next fetch.
- IF_over = (state == READY) & !cancel. It is a combinational mask, so ID never latches an instruction in a cancel cycle.
- Redirect from WB (exc_valid = 1), any state other than IDLE:
  - pc <= {exc_pc[31:2], 2'b00}.
  - inst_r content is discarded; state -> WAIT, cnt <= 0.
  - Takes priority over handoff and over jbr_taken in the same cycle.
- cancel = 1 with exc_valid = 0 (defensive case): pc is unchanged, state -> WAIT, cnt <= 0. The current pc is refetched.
- exc_valid or cancel during IDLE: ignored. IDLE always proceeds to WAIT at STARTADDR.
- Address rules:
  - pc[1:0] is forced to 00 on every load, including jbr_target.
  - pc+4 wraps modulo 2^32: 32'hFFFFFFFC -> 32'h00000000.
- Reset mid-operation (any state, any cnt) returns to IDLE on the next edge. Any in-flight ROM data is discarded.
- Priority order: reset > exc_valid/cancel > handoff (jbr, then pc+4) > hold.
- Steady-state throughput: one instruction per ROM_LAT+1 cycles when ID_allow_in is held at 1.

Test Plan:
- Reset, ROM_LAT=1, ROM[0]=32'h24010001, ID_allow_in=1 -> IF_over first rises in cycle 3 after reset release with IF_ID_bus={32'h0, 32'h24010001}. Next fetch: pc=32'h4.
- Hold ID_allow_in=0 for 5 cycles while READY at pc=8 -> IF_over stays 1 and IF_ID_bus is stable. Releasing allow_in gives exactly one handoff; pc=32'hC.
- At the handoff of pc=32'h10, drive jbr_bus={1, 32'h00000043} -> next inst_addr=32'h00000040. jbr_taken=1 in a non-handoff cycle -> no effect.
- exc_bus={1, 32'h0} with cancel=1 while in READY at pc=32'h20 -> IF_over=0 that cycle, no handoff, next inst_addr=32'h0. The same event issued in WAIT aborts the fetch and restarts the count.
- ROM_LAT=3 with ID_allow_in=1 -> IF_over pulses every 4 cycles. Assert reset mid-WAIT (cnt=1) -> IDLE, then fetch from STARTADDR.
- pc=32'hFFFFFFFC, no branch, handoff -> inst_addr=32'h00000000.
